// File: rtl/ramp_adc_sequencer.sv
// Ramp-compare ADC sequencer: settles and steps a shared PWM ramp DAC,
// captures each comparator channel's trip code, then drains the captured
// codes in ascending channel order over a valid/ready handshake.
module ramp_adc_sequencer #(
    parameter int WIDTH         = 8,
    parameter int NUM_CH        = 5,
    parameter int STEP_DIV      = 392,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        continuous,
    input  logic [NUM_CH-1:0]                           ch_enable,
    input  logic [NUM_CH-1:0]                           cmp_in,
    output logic [WIDTH-1:0]                            ramp_code,
    output logic                                        ramp_en,
    output logic                                        busy,
    output logic                                        result_valid,
    input  logic                                        result_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] result_ch,
    output logic [WIDTH-1:0]                            result_code,
    output logic                                        result_ovr,
    output logic                                        frame_done
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_MAX = (STEP_DIV > SETTLE_CYCLES) ? STEP_DIV : SETTLE_CYCLES;
    localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RAMP, DRAIN} state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              div_cnt;
    logic [NUM_CH-1:0]             mask;
    logic [NUM_CH-1:0]             pend;
    logic [NUM_CH-1:0]             cap;
    logic [NUM_CH-1:0]             trip;
    logic [NUM_CH-1:0]             ovr;
    logic [NUM_CH-1:0][WIDTH-1:0]  codes;
    logic [CH_W-1:0]               sel;

    logic frame_start, rearm, clr, settle_end, step_end, at_max, all_done, ramp_last, fin, accept;

    assign frame_start = (state == IDLE) && start && (|ch_enable);
    assign rearm       = (state == DRAIN) && (pend == '0) && continuous;
    assign clr         = frame_start || rearm;
    assign settle_end  = (state == SETTLE) && (div_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign step_end    = (state == RAMP) && (div_cnt == CNT_W'(STEP_DIV - 1));
    assign at_max      = (ramp_code == '1);
    // A channel counts as done if it already captured or trips on this step.
    assign all_done    = &(cap | trip | ~mask);
    assign ramp_last   = step_end && (at_max || all_done);
    assign fin         = step_end && at_max;
    assign accept      = result_valid && result_ready;

    // Per-channel synchronizer and sticky trip capture.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;

        // Shift the async comparator through the synchronizer chain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) sync_q <= '0;
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in[g]};
        end

        assign trip[g] = ~sync_q[SYNC_STAGES-1];

        // First trip wins; a channel still untripped after MAX is flagged overrange.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cap[g]   <= 1'b0;
                codes[g] <= '0;
                ovr[g]   <= 1'b0;
            end else if (clr) begin
                cap[g]   <= 1'b0;
                codes[g] <= '0;
                ovr[g]   <= 1'b0;
            end else if (step_end && mask[g] && !cap[g] && trip[g]) begin
                cap[g]   <= 1'b1;
                codes[g] <= ramp_code;
                ovr[g]   <= 1'b0;
            end else if (fin && mask[g] && !cap[g]) begin
                cap[g]   <= 1'b1;
                codes[g] <= '1;
                ovr[g]   <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        ramp_en   = (state == SETTLE) || (state == RAMP);
        case (state)
            IDLE:    if (frame_start) state_nxt = SETTLE;
            SETTLE:  if (settle_end)  state_nxt = RAMP;
            RAMP:    if (ramp_last)   state_nxt = DRAIN;
            DRAIN:   if (pend == '0)  state_nxt = continuous ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Cycle divider, ramp code, frame mask and drain bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            ramp_code <= '0;
            mask      <= '0;
            pend      <= '0;
        end else begin
            if (clr || settle_end || step_end)         div_cnt <= '0;
            else if (state == SETTLE || state == RAMP) div_cnt <= div_cnt + CNT_W'(1);

            if (frame_start)   ramp_code <= '0;
            else if (step_end) ramp_code <= ramp_last ? '0 : ramp_code + WIDTH'(1);

            if (frame_start)                mask <= ch_enable;
            else if (rearm && |ch_enable)   mask <= ch_enable;

            if (ramp_last)   pend      <= mask;
            else if (accept) pend[sel] <= 1'b0;
        end
    end

    // Lowest pending channel is the current beat.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend[i]) sel = CH_W'(i);
    end

    assign result_valid = (state == DRAIN) && (pend != '0);
    assign result_ch    = sel;
    assign result_code  = result_valid ? codes[sel] : '0;
    assign result_ovr   = result_valid && ovr[sel];
    assign frame_done   = (state == DRAIN) && (pend == '0);
endmodule

// File: tb/tb_ramp_adc_sequencer.sv
// Directed bench for ramp_adc_sequencer: table of frames with hand-computed
// beats and busy spans, plus reset, stall, mask-0 and continuous sequences.
module tb_ramp_adc_sequencer;
    localparam int W = 4, N = 5, SD = 4, SC = 3, SS = 2;

    logic         clk = 1'b0;
    logic         reset, start, continuous, result_ready;
    logic [N-1:0] ch_enable, cmp_in;
    logic [W-1:0] ramp_code, result_code;
    logic [2:0]   result_ch;
    logic         ramp_en, busy, result_valid, result_ovr, frame_done;

    int checks = 0, errors = 0;
    int cur_trip [N];

    ramp_adc_sequencer #(.WIDTH(W), .NUM_CH(N), .STEP_DIV(SD), .SETTLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .ch_enable(ch_enable), .cmp_in(cmp_in), .ramp_code(ramp_code), .ramp_en(ramp_en),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_ch(result_ch), .result_code(result_code), .result_ovr(result_ovr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Comparator model: output drops once the ramp reaches the channel's trip code.
    always_comb
        for (int i = 0; i < N; i++) cmp_in[i] = (int'(ramp_code) < cur_trip[i]);

    typedef struct {
        logic [N-1:0] mask;
        int trip [N];
        int nb;
        int ch [N];
        int code [N];
        int ovr [N];
        int busy;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({ramp_code, ramp_en, busy, result_valid, result_ch, result_code, result_ovr, frame_done});
    endfunction

    task automatic run_frame(input int idx, input int hold);
        int b, fd, bc, guard, hl;
        cur_trip     = vt[idx].trip;
        ch_enable    = vt[idx].mask;
        result_ready = (hold == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0; fd = 0; bc = 0; guard = 0; hl = hold;
        while (busy && guard < 400) begin
            guard++;
            bc++;
            start = (bc == 5);
            if (result_valid && hl == 0 && !result_ready) result_ready = 1'b1;
            if (result_valid) begin
                if (!result_ready) begin
                    chk($sformatf("v%0d_hold_ch", idx), int'(result_ch), vt[idx].ch[0]);
                    chk($sformatf("v%0d_hold_code", idx), int'(result_code), vt[idx].code[0]);
                    chk($sformatf("v%0d_hold_fd", idx), int'(frame_done), 0);
                    hl--;
                end else if (b < vt[idx].nb) begin
                    chk($sformatf("v%0d_b%0d_ch", idx, b), int'(result_ch), vt[idx].ch[b]);
                    chk($sformatf("v%0d_b%0d_code", idx, b), int'(result_code), vt[idx].code[b]);
                    chk($sformatf("v%0d_b%0d_ovr", idx, b), int'(result_ovr), vt[idx].ovr[b]);
                    b++;
                end else begin
                    chk($sformatf("v%0d_extra_beat", idx), b + 1, vt[idx].nb);
                end
            end
            if (frame_done) fd++;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_timeout", idx), int'(guard < 400), 1);
        chk($sformatf("v%0d_beats", idx), b, vt[idx].nb);
        chk($sformatf("v%0d_frame_done", idx), fd, 1);
        chk($sformatf("v%0d_busy_span", idx), bc, vt[idx].busy + hold);
    endtask

    initial begin
        int guard, nb;
        vt[0] = '{5'b11111, '{1, 4, 7, 10, 13}, 5, '{0, 1, 2, 3, 4}, '{1, 4, 7, 10, 13}, '{0, 0, 0, 0, 0}, 65};
        vt[1] = '{5'b00101, '{5, 0, 16, 0, 0},  2, '{0, 2, 0, 0, 0}, '{5, 15, 0, 0, 0},  '{0, 1, 0, 0, 0}, 70};
        vt[2] = '{5'b11111, '{0, 0, 0, 0, 0},   5, '{0, 1, 2, 3, 4}, '{0, 0, 0, 0, 0},   '{0, 0, 0, 0, 0}, 13};
        vt[3] = '{5'b01010, '{16, 15, 16, 3, 16}, 2, '{1, 3, 0, 0, 0}, '{15, 3, 0, 0, 0}, '{0, 0, 0, 0, 0}, 70};
        vt[4] = '{5'b10000, '{16, 16, 16, 16, 0}, 1, '{4, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 9};

        cur_trip = '{16, 16, 16, 16, 16};
        reset = 1'b0; start = 1'b0; continuous = 1'b0; result_ready = 1'b0; ch_enable = '0;
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", outs(), 0);

        for (int v = 0; v < 5; v++) run_frame(v, 0);

        // Consumer stalls 10 cycles on the first beat.
        run_frame(0, 10);

        // Reset mid-RAMP at code 6, then a clean frame.
        cur_trip = vt[0].trip; ch_enable = vt[0].mask; result_ready = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        guard = 0;
        while (ramp_code != 4'd6 && guard < 200) begin guard++; @(negedge clk); end
        chk("rst_reach_code6", int'(ramp_code), 6);
        #2 reset = 1'b0;
        #1 chk("rst_mid_outs", outs(), 0);
        @(negedge clk);
        chk("rst_hold_outs", outs(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_outs", outs(), 0);
        run_frame(3, 0);

        // start with an empty mask is ignored.
        ch_enable = '0; start = 1'b1; @(negedge clk); start = 1'b0;
        chk("mask0_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("mask0_busy_late", int'(busy), 0);

        // Continuous: SETTLE re-entered right after frame_done.
        cur_trip = vt[4].trip; ch_enable = 5'b10000; continuous = 1'b1; result_ready = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        guard = 0;
        while (!frame_done && guard < 200) begin guard++; @(negedge clk); end
        chk("cont_fd1", int'(frame_done), 1);
        @(negedge clk);
        chk("cont_rearm_busy", int'(busy), 1);
        chk("cont_rearm_en", int'(ramp_en), 1);
        chk("cont_rearm_code", int'(ramp_code), 0);
        continuous = 1'b0;
        guard = 0; nb = 0;
        while (!frame_done && guard < 200) begin
            if (result_valid) begin
                nb++;
                chk("cont_beat_ch", int'(result_ch), 4);
                chk("cont_beat_code", int'(result_code), 0);
            end
            guard++;
            @(negedge clk);
        end
        chk("cont_fd2", int'(frame_done), 1);
        chk("cont_beats", nb, 1);
        @(negedge clk);
        chk("cont_idle", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("cont_stay_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
